// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One queued fetch: instruction word tagged with its PC
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  // Decode-register action chosen each cycle, highest priority first
  typedef enum logic [1:0] {
    ACT_REDIRECT = 2'd0,
    ACT_STALL    = 2'd1,
    ACT_SPLIT    = 2'd2,
    ACT_NORMAL   = 2'd3
  } dec_act_t;

endpackage

// File: rtl/fetch_fifo.sv
// Dual-push / dual-pop circular buffer of fetch entries with occupancy count.
// Pushes always arrive as a pair; pops are 0, 1 or 2 per cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  fq_entry_t                i_wdata0,
  input  fq_entry_t                i_wdata1,
  input  logic [1:0]               i_pop_n,
  output fq_entry_t                o_head0,
  output fq_entry_t                o_head1,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  fq_entry_t         r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     w_wptr1;
  logic [PW-1:0]     w_rptr1;

  // Pointers are exactly log2(DEPTH) bits, so +1/+2 wrap for free
  assign w_wptr1 = r_wptr + PW'(1);
  assign w_rptr1 = r_rptr + PW'(1);

  assign o_head0 = r_mem[r_rptr];
  assign o_head1 = r_mem[w_rptr1];
  assign o_count = r_count;

  // Storage: write the pair at wptr and wptr+1 (may straddle the wrap)
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr]  <= i_wdata0;
      r_mem[w_wptr1] <= i_wdata1;
    end
  end

  // Pointer and occupancy update; clear discards everything
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PW'(2);
      r_rptr  <= r_rptr + PW'(i_pop_n);
      r_count <= r_count + (i_push ? CW'(2) : CW'(0)) - CW'(i_pop_n);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: fetches instruction pairs into a circular buffer and feeds
// two in-order decode lanes. Define FETCH_QUEUE_BYPASS_EN to let a fetched
// pair go straight into the decode registers when the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [31:0]            imem_addr,
  input  logic [31:0]            imem_rdata0,
  input  logic [31:0]            imem_rdata1,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic                   stall_d,
  input  logic                   split_d,
  output logic [31:0]            InstrD1,
  output logic [31:0]            PCD1,
  output logic                   ValidD1,
  output logic [31:0]            InstrD2,
  output logic [31:0]            PCD2,
  output logic                   ValidD2,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   r_addr;
  fq_entry_t     r_d1, r_d2;
  logic          r_v1, r_v2;

  dec_act_t      w_act;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_free;
  logic          w_fetch;
  logic          w_bypass;
  logic          w_push;
  logic [1:0]    w_pop_n;
  fq_entry_t     w_e0, w_e1;
  fq_entry_t     w_head0, w_head1;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (redirect_valid),
    .i_push   (w_push),
    .i_wdata0 (w_e0),
    .i_wdata1 (w_e1),
    .i_pop_n  (w_pop_n),
    .o_head0  (w_head0),
    .o_head1  (w_head1),
    .o_count  (w_count)
  );

  // Free space is judged on the start-of-cycle count
  assign w_free  = CW'(DEPTH) - w_count;
  assign w_fetch = !redirect_valid && (w_free >= CW'(2));
  assign w_e0    = '{pc: r_addr,          instr: imem_rdata0};
  assign w_e1    = '{pc: r_addr + 32'd4,  instr: imem_rdata1};

  // Pick the single decode action for this cycle
  always_comb begin
    w_act = ACT_NORMAL;
    if (redirect_valid)  w_act = ACT_REDIRECT;
    else if (stall_d)    w_act = ACT_STALL;
    else if (split_d)    w_act = ACT_SPLIT;
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = (w_act == ACT_NORMAL) && (w_count == '0) && w_fetch;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_fetch && !w_bypass;

  // Dequeue amount follows the action and the start-of-cycle count
  always_comb begin
    w_pop_n = 2'd0;
    case (w_act)
      ACT_SPLIT:  w_pop_n = (w_count >= CW'(1)) ? 2'd1 : 2'd0;
      ACT_NORMAL: begin
        if (w_bypass)                 w_pop_n = 2'd0;
        else if (w_count >= CW'(2))   w_pop_n = 2'd2;
        else if (w_count == CW'(1))   w_pop_n = 2'd1;
        else                          w_pop_n = 2'd0;
      end
      default:    w_pop_n = 2'd0;
    endcase
  end

  // Fetch PC: redirect overrides, otherwise advance by a pair when fetching
  always_ff @(posedge clk) begin
    if (rst)                 r_addr <= RESET_PC;
    else if (redirect_valid) r_addr <= redirect_pc;
    else if (w_fetch)        r_addr <= r_addr + 32'd8;
  end

  // Decode lane registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d1 <= '0;
      r_d2 <= '0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      case (w_act)
        ACT_REDIRECT: begin
          r_v1 <= 1'b0;
          r_v2 <= 1'b0;
        end
        ACT_STALL: ;
        ACT_SPLIT: begin
          r_d1 <= r_d2;
          r_v1 <= r_v2;
          r_d2 <= w_head0;
          r_v2 <= (w_count >= CW'(1));
        end
        default: begin
          if (w_bypass) begin
            r_d1 <= w_e0;
            r_d2 <= w_e1;
            r_v1 <= 1'b1;
            r_v2 <= 1'b1;
          end else begin
            r_d1 <= w_head0;
            r_d2 <= w_head1;
            r_v1 <= (w_count >= CW'(1));
            r_v2 <= (w_count >= CW'(2));
          end
        end
      endcase
    end
  end

  assign imem_addr = r_addr;
  assign InstrD1   = r_d1.instr;
  assign PCD1      = r_d1.pc;
  assign ValidD1   = r_v1;
  assign InstrD2   = r_d2.instr;
  assign PCD2      = r_d2.pc;
  assign ValidD2   = r_v2;
  assign count     = w_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: two instances (DEPTH 8 and 4) share control inputs
// and are compared every cycle against a queue-based reference model.
module tb_fetch_queue;
  import fetch_pkg::*;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  logic        clk;
  logic        rst, rv, st, sp;
  logic [31:0] rpc;

  logic [31:0] o_addr [2];
  logic [31:0] rd0 [2], rd1 [2];
  logic [31:0] o_in1 [2], o_pc1 [2], o_in2 [2], o_pc2 [2];
  logic        o_v1 [2], o_v2 [2];
  logic [3:0]  cnt0;
  logic [2:0]  cnt1;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] mpc [2];
  fq_entry_t   mq  [2][$];
  fq_entry_t   md1 [2], md2 [2];
  bit          mv1 [2], mv2 [2];

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_mem
    assign rd0[k] = imem(o_addr[k]);
    assign rd1[k] = imem(o_addr[k] + 32'd4);
  end

  fetch_queue #(.DEPTH(8)) dut0 (
    .clk(clk), .rst(rst), .imem_addr(o_addr[0]),
    .imem_rdata0(rd0[0]), .imem_rdata1(rd1[0]),
    .redirect_valid(rv), .redirect_pc(rpc), .stall_d(st), .split_d(sp),
    .InstrD1(o_in1[0]), .PCD1(o_pc1[0]), .ValidD1(o_v1[0]),
    .InstrD2(o_in2[0]), .PCD2(o_pc2[0]), .ValidD2(o_v2[0]),
    .count(cnt0)
  );

  fetch_queue #(.DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .imem_addr(o_addr[1]),
    .imem_rdata0(rd0[1]), .imem_rdata1(rd1[1]),
    .redirect_valid(rv), .redirect_pc(rpc), .stall_d(st), .split_d(sp),
    .InstrD1(o_in1[1]), .PCD1(o_pc1[1]), .ValidD1(o_v1[1]),
    .InstrD2(o_in2[1]), .PCD2(o_pc2[1]), .ValidD2(o_v2[1]),
    .count(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // One cycle of the behavioural model for instance k of depth dep
  task automatic model_step(input int k, input int dep);
    fq_entry_t e0, e1;
    int c;
    bit fe, byp;
    if (rst) begin
      mpc[k] = RESET_PC_DEFAULT;
      mq[k].delete();
      md1[k] = '0; md2[k] = '0;
      mv1[k] = 0;  mv2[k] = 0;
    end else begin
      c   = mq[k].size();
      fe  = !rv && (dep - c >= 2);
      byp = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
      byp = !rv && !st && !sp && (c == 0) && fe;
`endif
      e0 = '{pc: mpc[k],         instr: imem(mpc[k])};
      e1 = '{pc: mpc[k] + 32'd4, instr: imem(mpc[k] + 32'd4)};
      if (rv) begin
        mq[k].delete();
        mv1[k] = 0; mv2[k] = 0;
        mpc[k] = rpc;
      end else begin
        if (st) begin
        end else if (sp) begin
          md1[k] = md2[k]; mv1[k] = mv2[k];
          mv2[k] = (c >= 1);
          if (c >= 1) md2[k] = mq[k].pop_front();
        end else if (byp) begin
          md1[k] = e0; md2[k] = e1; mv1[k] = 1; mv2[k] = 1;
        end else begin
          mv1[k] = (c >= 1);
          if (c >= 1) md1[k] = mq[k].pop_front();
          mv2[k] = (c >= 2);
          if (c >= 2) md2[k] = mq[k].pop_front();
        end
        if (fe && !byp) begin
          mq[k].push_back(e0);
          mq[k].push_back(e1);
        end
        if (fe) mpc[k] = mpc[k] + 32'd8;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] oc;
    for (int k = 0; k < 2; k++) begin
      oc = (k == 0) ? 32'(cnt0) : 32'(cnt1);
      chk($sformatf("u%0d.imem_addr", k), o_addr[k], mpc[k]);
      chk($sformatf("u%0d.count", k), oc, 32'(mq[k].size()));
      chk($sformatf("u%0d.ValidD1", k), 32'(o_v1[k]), 32'(mv1[k]));
      chk($sformatf("u%0d.ValidD2", k), 32'(o_v2[k]), 32'(mv2[k]));
      if (mv1[k]) begin
        chk($sformatf("u%0d.PCD1", k), o_pc1[k], md1[k].pc);
        chk($sformatf("u%0d.InstrD1", k), o_in1[k], md1[k].instr);
      end
      if (mv2[k]) begin
        chk($sformatf("u%0d.PCD2", k), o_pc2[k], md2[k].pc);
        chk($sformatf("u%0d.InstrD2", k), o_in2[k], md2[k].instr);
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [31:0] p, input bit s, input bit q);
    rst = r; rv = v; rpc = p; st = s; sp = q;
    @(posedge clk);
    model_step(0, 8);
    model_step(1, 4);
    #1;
    check_all();
  endtask

  initial begin
    int lat;
    bit found;
    logic [31:0] a_hold, p1_hold, p2_hold;
    rst = 1; rv = 0; rpc = '0; st = 0; sp = 0;

    // Reset: everything cleared, fetch at RESET_PC
    step(1, 0, 0, 0, 0);
    chk("rst.PCD1", o_pc1[0], 32'h0);
    chk("rst.InstrD2", o_in2[0], 32'h0);

    // Free run from reset: first pair 0/4, then 8/12
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      step(0, 0, 0, 0, 0);
      if (o_v1[0]) found = 1;
    end
    chk("run.found", 32'(found), 32'd1);
    chk("run.PCD1a", o_pc1[0], 32'h0);
    chk("run.PCD2a", o_pc2[0], 32'h4);
    step(0, 0, 0, 0, 0);
    chk("run.PCD1b", o_pc1[0], 32'h8);
    chk("run.PCD2b", o_pc2[0], 32'hC);
    chk("run.V2b", 32'(o_v2[0]), 32'd1);

    // Redirect with 6 entries queued, then measure redirect-to-valid latency
    step(0, 1, 32'h200, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    chk("redir.pre_count", 32'(cnt0), 32'd6);
    step(0, 1, 32'h100, 0, 0);
    chk("redir.count0", 32'(cnt0), 32'd0);
    lat = 1; found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      step(0, 0, 0, 0, 0);
      lat++;
      if (o_v1[0]) found = 1;
    end
    chk("redir.latency", 32'(lat), 32'(LAT));
    chk("redir.PCD1", o_pc1[0], 32'h100);
    chk("redir.PCD2", o_pc2[0], 32'h104);

    // Stall held 5 cycles: lanes frozen, queue fills to DEPTH, fetch stops
    step(0, 1, 32'h400, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    p1_hold = o_pc1[0]; p2_hold = o_pc2[0];
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 0);
      if (i == 2) a_hold = o_addr[0];
    end
    chk("stall.count", 32'(cnt0), 32'd8);
    chk("stall.addr_frozen", o_addr[0], a_hold);
    chk("stall.addr", o_addr[0], 32'h428);
    chk("stall.PCD1", o_pc1[0], p1_hold);
    chk("stall.PCD2", o_pc2[0], p2_hold);
    chk("stall.PCD1c", o_pc1[0], 32'h400);

    // Split: D1=0x20, D2=0x24, head 0x28
    step(0, 1, 32'h20, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("split.PCD1", o_pc1[0], 32'h24);
    chk("split.PCD2", o_pc2[0], 32'h28);

    // Redirect beats stall; reset beats redirect
    step(0, 1, 32'h300, 1, 0);
    chk("rs.addr", o_addr[0], 32'h300);
    step(1, 1, 32'h500, 0, 0);
    chk("rst_redir.addr", o_addr[0], RESET_PC_DEFAULT);

    // DEPTH=4 instance: reach count=1 in normal -> only lane 1 valid
    step(0, 1, 32'hFFFF_FFF0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("c1.count", 32'(cnt1), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("c1.V1", 32'(o_v1[1]), 32'd1);
    chk("c1.V2", 32'(o_v2[1]), 32'd0);

    // Random traffic; model checks ordering across pointer wraps
    for (int i = 0; i < 600; i++) begin
      bit r, v, s, q;
      logic [31:0] p;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 15) == 0);
      s = ($urandom_range(0, 3) == 0);
      q = ($urandom_range(0, 4) == 0);
      p = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      step(r, v, p, s, q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entries; power of two, >= 4.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  in  1  clock; one clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have ports imem_addr  out  32  fetch PC; imem_rdata0 / imem_rdata1  in  32  instructions at imem_addr and imem_addr+4, combinational, same cycle.
REQ-006 SHALL have ports redirect_valid  in  1  taken branch/jump from execute; redirect_pc  in  32  target.
REQ-007 SHALL have ports stall_d  in  1  hold both decode lanes; split_d  in  1  lane 2 held, lane 1 bubbled.
REQ-008 SHALL have ports InstrD1 / PCD1  out  32 / 32  and ValidD1  out  1  lane-1 decode register.
REQ-009 SHALL have ports InstrD2 / PCD2  out  32 / 32  and ValidD2  out  1  lane-2 decode register.
REQ-010 SHALL have port count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-011 SHALL store {pc, instr} entries in a circular buffer with wrapping read/write pointers and occupancy counter 0..DEPTH.
REQ-012 SHALL fetch when free slots >= 2 and no redirect: enqueue {imem_addr, imem_rdata0} then {imem_addr+4, imem_rdata1}; imem_addr += 8; otherwise imem_addr holds.
REQ-013 SHALL, per cycle, apply exactly one decode action in priority order: redirect > stall_d > split_d > normal.
REQ-014 SHALL, on redirect_valid: clear queue (count=0), clear ValidD1/ValidD2, set imem_addr := redirect_pc; no enqueue that cycle.
REQ-015 SHALL, on stall_d: hold D1/D2 unchanged, dequeue nothing; fetch per REQ-012 continues.
REQ-016 SHALL, on split_d: D1 := previous D2 contents/valid; D2 := queue head (valid iff count>=1); dequeue 1 or 0.
REQ-017 SHALL, in normal: D1 := head, D2 := head+1; dequeue min(count,2); count=1 -> ValidD2=0; count=0 -> both valid 0.
REQ-018 SHALL preserve program order: PCD1 precedes PCD2 whenever both valid.
REQ-019 SHALL compute dequeue eligibility from the count at the start of the cycle; same-cycle enqueue and dequeue allowed; count_next = count + enq - deq, never > DEPTH or < 0.
REQ-020 SHALL treat pointer wrap at DEPTH-1 -> 0 transparently, including a 2-entry push/pop straddling the wrap.
REQ-021 SHALL, with count=DEPTH-1, not fetch (only 1 free slot).
REQ-022 SHALL add PC arithmetic modulo 2^32.

Reset
REQ-023 SHALL on rst: imem_addr=RESET_PC, count=0, pointers=0, ValidD1=ValidD2=0, InstrD*/PCD*=0.
REQ-024 SHALL give rst priority over redirect_valid, stall_d, split_d; reset mid-operation discards all entries.

Configuration
REQ-025 SHALL support macro FETCH_QUEUE_BYPASS_EN.
REQ-026 SHALL, with it defined, in normal action with count=0 and fetch enabled, load imem pair straight into D1/D2 (no enqueue); redirect-to-valid latency 2 edges.
REQ-027 SHALL, without it, always route through the queue; redirect-to-valid latency 3 edges.

Structure
REQ-028 SHALL place fq_entry_t {pc, instr}, and RESET_PC default in shared package fetch_pkg.
REQ-029 SHALL instantiate one sub-module fetch_fifo: dual-push/dual-pop circular buffer with count; fetch_queue holds PC and decode registers.

Verification
REQ-030 SHALL cover: reset, then free run, RESET_PC=0 -> lanes show PC 0/4, then 8/12, ValidD1=ValidD2=1.
REQ-031 SHALL cover: redirect_pc=0x100 while 6 entries queued -> count=0 next edge, next valid pair PCD1=0x100, PCD2=0x104, latency per REQ-026/027.
REQ-032 SHALL cover: stall_d held 5 cycles -> D1/D2 unchanged, count rises to DEPTH (8) then stops, imem_addr frozen.
REQ-033 SHALL cover: D1=0x20, D2=0x24, head 0x28; split_d one cycle -> PCD1=0x24, PCD2=0x28, count drops by 1.
REQ-034 SHALL cover: redirect and stall_d same cycle -> redirect wins; rst with redirect -> imem_addr=RESET_PC.
REQ-035 SHALL cover: count=1 in normal -> ValidD1=1, ValidD2=0; pointers wrapping past DEPTH-1 keep PC order intact.
